instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the read-only instruction memory.
- Owns the program counter and drives the memory's 64-bit byte address.
- Waits a parameterised number of cycles for the 32-bit instruction word, then captures it with its PC into a valid/ready output register for decode.
- Accepts branch redirects (B, CBZ taken) from the next-PC logic and flushes any held instruction.

Parameters:
- MEM_WAIT, 1: full clock cycles the Address must be stable before Data is sampled. Legal values are ≥1.
- RESET_PC, 64'h0: PC value loaded on reset.
- AGE_W, 4: width of the address-age counter. Requires 2^AGE_W > MEM_WAIT.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Address  output  64  byte address to instruction memory; equals PC register
- Data  input  32  instruction word from instruction memory
- Instruction  output  32  captured instruction word
- InstPC  output  64  address Instruction was fetched from
- Valid  output  1  Instruction/InstPC hold a fetched, unconsumed word
- Ready  input  1  decode accepts the word this cycle
- Redirect  input  1  load RedirectPC and flush
- RedirectPC  input  64  branch target
- FetchCount  output  32  number of words accepted by decode (Valid&&Ready edges)

Behaviour:
- Reset (async, any time, including mid-wait or while Valid):
  - PC=RESET_PC, Instruction=0, InstPC=0, Valid=0, age=0, FetchCount=0.
  - Address=RESET_PC immediately.
- Address is driven combinationally from the PC register only. It never changes except on a clock edge or on reset.
- age counter:
  - Cleared whenever PC is written.
  - Otherwise increments each edge, saturating at MEM_WAIT-1.
  - data_ok = (age == MEM_WAIT-1), i.e. Address has been stable for MEM_WAIT full cycles at this edge.
- Output register has two states:
  - EMPTY: Valid=0.
  - FULL: Valid=1.
- Per rising edge, priority order:
  1. Redirect=1:
     - PC<={RedirectPC[63:2],2'b00}. Misaligned targets are silently aligned down.
     - age<=0, Valid<=0 (held word discarded, not counted).
     - Instruction/InstPC unchanged.
     - If Valid&&Ready in the same cycle, FetchCount still increments (decode consumed it).
  2. capture = data_ok && (!Valid || Ready):
     - Instruction<=Data, InstPC<=PC, Valid<=1, PC<=PC+4, age<=0.
  3. Valid && Ready && !data_ok:
     - Valid<=0; age increments.
  4. Otherwise:
     - Hold Instruction/InstPC/Valid/PC; age increments (prefetch of PC continues while FULL).
- FetchCount increments on every edge with Valid&&Ready, independent of the other events. It wraps mod 2^32.
- Throughput: with MEM_WAIT=1 and Ready held 1, one instruction per cycle, and Valid stays high continuously.
- Latency: first Valid rises at the MEM_WAIT-th edge after reset release or after a redirect edge.
- PC+4 wraps mod 2^64 (0xFFFF_FFFF_FFFF_FFFC → 0x0).
- Valid, once high, stays high with Instruction/InstPC stable until consumed (Ready) or flushed (Redirect/Reset).
- Data containing X is captured as-is; the block does not check it.

Test Plan:
1. Reset then release, MEM_WAIT=1, Ready=1, memory loaded with the test program:
   - Edge 1: Valid=1, InstPC=0x0, Instruction=F84003E9.
   - Edge 2: InstPC=0x4, F84083EA.
   - Edge 3: InstPC=0x8, F84103EB.
   - FetchCount=2 after edge 3.
2. Backpressure: Ready=0 for 4 cycles while FULL at InstPC=0x14 (AA0B014A):
   - Outputs stay constant and Address stays 0x18.
   - Ready=1 → next edge InstPC=0x18, 8A0A018C.
3. Redirect with RedirectPC=0x20 while FULL at InstPC=0x28 with Ready=0:
   - Next edge Valid=0, Address=0x20, FetchCount unchanged.
   - Following edge Valid=1, InstPC=0x20, Instruction=8B0901AD.
4. Misaligned redirect RedirectPC=0x2F:
   - Address=0x2C, then InstPC=0x2C, Instruction=F80203ED.
5. MEM_WAIT=3, Ready=1:
   - Valid first at edge 3 (InstPC=0x0), then InstPC=0x4 at edge 6.
   - Valid low for 2 cycles between words; no word duplicated or skipped.
6. Reset asserted asynchronously mid-wait (MEM_WAIT=3, age=1) and mid-FULL:
   - Address returns to RESET_PC and Valid=0 without a clock edge.
   - FetchCount=0.
   - After release, sequence restarts at InstPC=0x0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and fetch stage feeding decode through a valid/ready output register.
// Ports:
//   CLK, Reset      clock and asynchronous active-high reset
//   Address         byte address to instruction memory (the PC register)
//   Data            instruction word returned by memory
//   Instruction     captured word; InstPC is the address it came from
//   Valid / Ready   output handshake towards decode
//   Redirect        load RedirectPC (aligned down to a word) and flush the held word
//   FetchCount      number of words accepted by decode, wrapping
module instruction_fetch_unit #(
    parameter int          MEM_WAIT = 1,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          AGE_W    = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] Address,
    input  logic [31:0] Data,
    output logic [31:0] Instruction,
    output logic [63:0] InstPC,
    output logic        Valid,
    input  logic        Ready,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic [31:0] FetchCount
);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MEM_WAIT - 1);
    logic [63:0] pc_q, pc_d, inst_pc_q, inst_pc_d;
    logic [31:0] instr_q, instr_d, count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic valid_q, valid_d, data_ok, take, capture;
    // data_ok: Address has been stable for MEM_WAIT full cycles at this edge
    assign data_ok = age_q == AGE_MAX;
    assign take    = valid_q && Ready;
    assign capture = data_ok && (!valid_q || Ready);
    always_comb begin
        pc_d      = Redirect ? {RedirectPC[63:2], 2'b00} : capture ? pc_q + 64'd4 : pc_q;
        // age saturates so a long FULL stall leaves the prefetched word ready to capture
        age_d     = (Redirect || capture) ? '0 : data_ok ? age_q : age_q + AGE_W'(1);
        valid_d   = Redirect ? 1'b0 : capture ? 1'b1 : take ? 1'b0 : valid_q;
        instr_d   = (!Redirect && capture) ? Data : instr_q;
        inst_pc_d = (!Redirect && capture) ? pc_q : inst_pc_q;
        // a consumed word is counted even when a redirect lands on the same edge
        count_d   = count_q + {31'b0, take};
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q      <= RESET_PC;
            age_q     <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            age_q     <= age_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            inst_pc_q <= inst_pc_d;
            count_q   <= count_d;
        end
    end
    assign Address     = pc_q;
    assign Instruction = instr_q;
    assign InstPC      = inst_pc_q;
    assign Valid       = valid_q;
    assign FetchCount  = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for the fetch unit with MEM_WAIT=1 and MEM_WAIT=3 instances.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a[5:2])
            4'd0:  rom = 32'hF84003E9;
            4'd1:  rom = 32'hF84083EA;
            4'd2:  rom = 32'hF84103EB;
            4'd3:  rom = 32'h8B090129;
            4'd4:  rom = 32'hCB0A014A;
            4'd5:  rom = 32'hAA0B014A;
            4'd6:  rom = 32'h8A0A018C;
            4'd7:  rom = 32'hD503201F;
            4'd8:  rom = 32'h8B0901AD;
            4'd9:  rom = 32'hB40000E0;
            4'd10: rom = 32'h17FFFFF6;
            4'd11: rom = 32'hF80203ED;
            4'd15: rom = 32'h14000000;
            default: rom = 32'hD503201F;
        endcase
    endfunction
    logic        ra, rdy_a, rd_a, v_a;
    logic [63:0] addr_a, ipc_a, rdpc_a;
    logic [31:0] data_a, ins_a, cnt_a;
    assign data_a = rom(addr_a);
    instruction_fetch_unit #(.MEM_WAIT(1)) dut_a (
        .CLK(CLK), .Reset(ra), .Address(addr_a), .Data(data_a), .Instruction(ins_a),
        .InstPC(ipc_a), .Valid(v_a), .Ready(rdy_a), .Redirect(rd_a), .RedirectPC(rdpc_a),
        .FetchCount(cnt_a)
    );
    logic        rb, rdy_b, rd_b, v_b;
    logic [63:0] addr_b, ipc_b, rdpc_b;
    logic [31:0] data_b, ins_b, cnt_b;
    assign data_b = rom(addr_b);
    instruction_fetch_unit #(.MEM_WAIT(3)) dut_b (
        .CLK(CLK), .Reset(rb), .Address(addr_b), .Data(data_b), .Instruction(ins_b),
        .InstPC(ipc_b), .Valid(v_b), .Ready(rdy_b), .Redirect(rd_b), .RedirectPC(rdpc_b),
        .FetchCount(cnt_b)
    );
    int errors = 0;
    int checks = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask
    initial begin
        ra = 1'b1; rdy_a = 1'b1; rd_a = 1'b0; rdpc_a = '0;
        rb = 1'b1; rdy_b = 1'b1; rd_b = 1'b0; rdpc_b = '0;
        #2;
        chk("rst_addr", addr_a, 64'h0);
        chk("rst_valid", v_a, 1'b0);
        chk("rst_instr", ins_a, 32'h0);
        chk("rst_instpc", ipc_a, 64'h0);
        chk("rst_count", cnt_a, 32'h0);
        @(negedge CLK) ra = 1'b0;
        tick(1);
        chk("e1_valid", v_a, 1'b1);
        chk("e1_instpc", ipc_a, 64'h0);
        chk("e1_instr", ins_a, 32'hF84003E9);
        chk("e1_count", cnt_a, 32'd0);
        tick(1);
        chk("e2_instpc", ipc_a, 64'h4);
        chk("e2_instr", ins_a, 32'hF84083EA);
        tick(1);
        chk("e3_instpc", ipc_a, 64'h8);
        chk("e3_instr", ins_a, 32'hF84103EB);
        chk("e3_count", cnt_a, 32'd2);
        tick(3);
        chk("e6_instpc", ipc_a, 64'h14);
        chk("e6_count", cnt_a, 32'd5);
        rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bp_valid", v_a, 1'b1);
            chk("bp_instpc", ipc_a, 64'h14);
            chk("bp_instr", ins_a, 32'hAA0B014A);
            chk("bp_addr", addr_a, 64'h18);
            chk("bp_count", cnt_a, 32'd5);
        end
        rdy_a = 1'b1;
        tick(1);
        chk("bp_rel_instpc", ipc_a, 64'h18);
        chk("bp_rel_instr", ins_a, 32'h8A0A018C);
        chk("bp_rel_count", cnt_a, 32'd6);
        tick(4);
        chk("e15_instpc", ipc_a, 64'h28);
        chk("e15_count", cnt_a, 32'd10);
        rdy_a = 1'b0; rd_a = 1'b1; rdpc_a = 64'h20;
        tick(1);
        rd_a = 1'b0;
        chk("redir_valid", v_a, 1'b0);
        chk("redir_addr", addr_a, 64'h20);
        chk("redir_count", cnt_a, 32'd10);
        chk("redir_instpc_hold", ipc_a, 64'h28);
        tick(1);
        chk("redir_cap_valid", v_a, 1'b1);
        chk("redir_cap_instpc", ipc_a, 64'h20);
        chk("redir_cap_instr", ins_a, 32'h8B0901AD);
        rdy_a = 1'b1; rd_a = 1'b1; rdpc_a = 64'h2F;
        tick(1);
        rd_a = 1'b0;
        chk("mis_addr", addr_a, 64'h2C);
        chk("mis_valid", v_a, 1'b0);
        chk("mis_count_take", cnt_a, 32'd11);
        tick(1);
        chk("mis_instpc", ipc_a, 64'h2C);
        chk("mis_instr", ins_a, 32'hF80203ED);
        chk("mis_count", cnt_a, 32'd11);
        rd_a = 1'b1; rdpc_a = 64'hFFFF_FFFF_FFFF_FFFE;
        tick(1);
        rd_a = 1'b0;
        chk("wrap_addr", addr_a, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_count", cnt_a, 32'd12);
        tick(1);
        chk("wrap_instpc", ipc_a, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", ins_a, 32'h14000000);
        chk("wrap_next_addr", addr_a, 64'h0);
        @(negedge CLK) rb = 1'b0;
        tick(2);
        chk("w3_e2_valid", v_b, 1'b0);
        chk("w3_e2_addr", addr_b, 64'h0);
        tick(1);
        chk("w3_e3_valid", v_b, 1'b1);
        chk("w3_e3_instpc", ipc_b, 64'h0);
        chk("w3_e3_instr", ins_b, 32'hF84003E9);
        tick(1);
        chk("w3_e4_valid", v_b, 1'b0);
        chk("w3_e4_count", cnt_b, 32'd1);
        tick(1);
        chk("w3_e5_valid", v_b, 1'b0);
        tick(1);
        chk("w3_e6_valid", v_b, 1'b1);
        chk("w3_e6_instpc", ipc_b, 64'h4);
        chk("w3_e6_instr", ins_b, 32'hF84083EA);
        chk("w3_e6_count", cnt_b, 32'd1);
        tick(1);
        chk("w3_e7_addr", addr_b, 64'h8);
        chk("w3_e7_count", cnt_b, 32'd2);
        #2 rb = 1'b1;
        #1;
        chk("arst_wait_addr", addr_b, 64'h0);
        chk("arst_wait_valid", v_b, 1'b0);
        chk("arst_wait_count", cnt_b, 32'd0);
        @(negedge CLK) rb = 1'b0;
        tick(3);
        chk("arst_full_pre_valid", v_b, 1'b1);
        chk("arst_full_pre_addr", addr_b, 64'h4);
        rdy_b = 1'b0;
        #2 rb = 1'b1;
        #1;
        chk("arst_full_addr", addr_b, 64'h0);
        chk("arst_full_valid", v_b, 1'b0);
        chk("arst_full_instpc", ipc_b, 64'h0);
        @(negedge CLK) begin rb = 1'b0; rdy_b = 1'b1; end
        tick(2);
        chk("restart_e2_valid", v_b, 1'b0);
        tick(1);
        chk("restart_valid", v_b, 1'b1);
        chk("restart_instpc", ipc_b, 64'h0);
        chk("restart_instr", ins_b, 32'hF84003E9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
